// File: rtl/feistel_seq_pkg.sv
// Shared constants and types for the Feistel core sequencer: host opcodes,
// core command bytes and the controller state encoding.
package feistel_seq_pkg;

    localparam int KEY_BYTES = 16;

    localparam logic [1:0] OP_LOAD_KEY  = 2'b00;
    localparam logic [1:0] OP_SET_START = 2'b01;
    localparam logic [1:0] OP_STREAM    = 2'b10;
    localparam logic [1:0] OP_RSVD      = 2'b11;

    // Any of these on an idle core starts a command, so idle drive is 0x00.
    localparam logic [7:0] CORE_CMD_KEY    = 8'h01;
    localparam logic [7:0] CORE_CMD_SEG    = 8'h0F;
    localparam logic [7:0] CORE_CMD_STREAM = 8'h02;

    typedef enum logic [3:0] {
        S_IDLE,
        S_KEY_CMD,
        S_KEY_DATA,
        S_ST_CMD,
        S_ST_ARG,
        S_WAIT_DATA,
        S_STR_CMD,
        S_STR_PAD,
        S_STR_DATA,
        S_DRAIN
    } state_e;

endpackage

// File: rtl/feistel_seq_ctrl_if.sv
// Host-side bundle of the sequencer: command handshake, input byte stream and
// result strobe. The controller uses the slave modport, the host the master.
interface feistel_seq_ctrl_if;
    logic         cmd_valid;
    logic         cmd_ready;
    logic [1:0]   cmd_op;
    logic [7:0]   cmd_arg;
    logic         cmd_dec;
    logic [127:0] cmd_key;
    logic         din_valid;
    logic         din_ready;
    logic [7:0]   din_byte;
    logic         dout_valid;
    logic [7:0]   dout_byte;

    modport master (
        output cmd_valid, cmd_op, cmd_arg, cmd_dec, cmd_key, din_valid, din_byte,
        input  cmd_ready, din_ready, dout_valid, dout_byte
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, cmd_dec, cmd_key, din_valid, din_byte,
        output cmd_ready, din_ready, dout_valid, dout_byte
    );
endinterface

// File: rtl/feistel_seq_fifo.sv
// Synchronous byte FIFO with occupancy count; read data is shown from the head
// entry combinationally so a pop cycle can forward it directly.
module feistel_seq_fifo #(
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_i,
    input  logic [7:0]    wdata_i,
    input  logic          pop_i,
    output logic [7:0]    rdata_o,
    output logic          full_o,
    output logic [AW:0]   count_o
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          push_ok, pop_ok;

    assign full_o  = (count_q == FULL_CNT);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && (count_q != '0);
    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q] <= wdata_i;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/feistel_seq_ctrl.sv
// Host-command sequencer for the byte-serial Feistel core. Optional build macro
// FEISTEL_SEQ_RESYNC_EN re-sends the last start segment before every stream.
//
// state      | meaning
// IDLE       | accepting a host command
// KEY_CMD    | key-load command byte to core
// KEY_DATA   | 16 key bytes, MSB byte first
// ST_CMD     | set-segment command byte
// ST_ARG     | segment byte
// WAIT_DATA  | waiting for L bytes in the FIFO
// STR_CMD    | stream command byte
// STR_PAD    | sacrificial pad byte
// STR_DATA   | L data bytes popped from FIFO
// DRAIN      | last core result still in flight
module feistel_seq_ctrl
    import feistel_seq_pkg::*;
#(
    parameter int DIN_DEPTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    feistel_seq_ctrl_if.slave  bus,
    output logic               busy_o,
    output logic [7:0]         cph_ui_o,
    output logic [7:0]         cph_uio_o,
    input  logic [7:0]         cph_uo_i
);

    localparam int CW = $clog2(DIN_DEPTH) + 1;

    state_e         state_q, state_d;
    logic [3:0]     cnt_q, cnt_d;
    logic [3:0]     len_q;
    logic [7:0]     seg_q;
    logic           dec_q;
    logic [127:0]   key_q;
    logic           mode_q;
    logic           str_prev_q;
    logic           dout_valid_q;
    logic [7:0]     dout_byte_q;

    logic           cmd_fire;
    logic           pop;
    logic           end_stream;
    logic [7:0]     ui;
    logic [7:0]     fifo_rdata;
    logic           fifo_full;
    logic [CW-1:0]  fifo_count;

    feistel_seq_fifo #(.DEPTH(DIN_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (bus.din_valid),
        .wdata_i (bus.din_byte),
        .pop_i   (pop),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .count_o (fifo_count)
    );

    assign cmd_fire = bus.cmd_valid && (state_q == S_IDLE);

`ifdef FEISTEL_SEQ_RESYNC_EN
    logic str_pend_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           str_pend_q <= 1'b0;
        else if (cmd_fire) str_pend_q <= (bus.cmd_op == OP_STREAM);
    end
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ui         = 8'h00;
        end_stream = 1'b0;
        pop        = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    case (bus.cmd_op)
                        OP_LOAD_KEY:  state_d = S_KEY_CMD;
                        OP_SET_START: state_d = S_ST_CMD;
`ifdef FEISTEL_SEQ_RESYNC_EN
                        OP_STREAM:    state_d = S_ST_CMD;
`else
                        OP_STREAM:    state_d = (fifo_count > CW'(bus.cmd_arg[3:0]))
                                                ? S_STR_CMD : S_WAIT_DATA;
`endif
                        default:      state_d = S_IDLE;
                    endcase
                end
            end
            S_KEY_CMD: begin
                ui      = CORE_CMD_KEY;
                cnt_d   = 4'(KEY_BYTES - 1);
                state_d = S_KEY_DATA;
            end
            S_KEY_DATA: begin
                // cnt_q counts down from 15, so it doubles as the byte lane index
                ui    = key_q[{cnt_q, 3'b000} +: 8];
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd0) state_d = S_IDLE;
            end
            S_ST_CMD: begin
                ui      = CORE_CMD_SEG;
                state_d = S_ST_ARG;
            end
            S_ST_ARG: begin
                ui      = seg_q;
                state_d = S_IDLE;
`ifdef FEISTEL_SEQ_RESYNC_EN
                if (str_pend_q)
                    state_d = (fifo_count > CW'(len_q)) ? S_STR_CMD : S_WAIT_DATA;
`endif
            end
            S_WAIT_DATA: begin
                if (fifo_count > CW'(len_q)) state_d = S_STR_CMD;
            end
            S_STR_CMD: begin
                ui      = CORE_CMD_STREAM;
                state_d = S_STR_PAD;
            end
            S_STR_PAD: begin
                cnt_d   = len_q;
                state_d = S_STR_DATA;
            end
            S_STR_DATA: begin
                ui         = fifo_rdata;
                pop        = 1'b1;
                end_stream = (cnt_q == 4'd0);
                cnt_d      = cnt_q - 4'd1;
                if (cnt_q == 4'd0) state_d = S_DRAIN;
            end
            S_DRAIN: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            len_q        <= '0;
            seg_q        <= '0;
            dec_q        <= 1'b0;
            key_q        <= '0;
            mode_q       <= 1'b0;
            str_prev_q   <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_byte_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (cmd_fire) begin
                len_q <= bus.cmd_arg[3:0];
                dec_q <= bus.cmd_dec;
                key_q <= bus.cmd_key;
                if (bus.cmd_op == OP_SET_START) seg_q <= bus.cmd_arg;
            end
            // Streams entered straight from IDLE have not latched dec yet
            if (state_d == S_STR_CMD && state_q != S_STR_CMD)
                mode_q <= cmd_fire ? bus.cmd_dec : dec_q;
            str_prev_q   <= (state_q == S_STR_DATA);
            dout_valid_q <= str_prev_q;
            if (str_prev_q) dout_byte_q <= cph_uo_i;
        end
    end

    assign bus.cmd_ready  = (state_q == S_IDLE);
    assign bus.din_ready  = !fifo_full;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout_byte  = dout_byte_q;
    assign busy_o         = (state_q != S_IDLE);
    assign cph_ui_o       = ui;
    assign cph_uio_o      = {6'b000000, end_stream, mode_q};

endmodule

// File: tb/tb_feistel_seq_ctrl.sv
// Directed bench for feistel_seq_ctrl with a behavioural cipher core and a
// scoreboard of expected result bytes.
module tb_feistel_seq_ctrl;
    import feistel_seq_pkg::*;

`ifdef FEISTEL_SEQ_RESYNC_EN
    localparam bit RESYNC = 1'b1;
    localparam int PRE    = 2;
`else
    localparam bit RESYNC = 1'b0;
    localparam int PRE    = 0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    feistel_seq_ctrl_if bus();
    logic       busy;
    logic [7:0] cph_ui, cph_uio, cph_uo;

    feistel_seq_ctrl #(.DIN_DEPTH(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .busy_o    (busy),
        .cph_ui_o  (cph_ui),
        .cph_uio_o (cph_uio),
        .cph_uo_i  (cph_uo)
    );

    // golden nibble Feistel, two rounds keyed by the low then high key nibble
    function automatic logic [3:0] rf(input logic [3:0] x, input logic [3:0] k);
        return ({x[2:0], x[3]} + k) ^ 4'h9;
    endfunction
    function automatic logic [7:0] genc(input logic [7:0] b, input logic [7:0] k);
        logic [3:0] l, r, t;
        l = b[7:4]; r = b[3:0];
        t = l ^ rf(r, k[3:0]); l = r; r = t;
        t = l ^ rf(r, k[7:4]); l = r; r = t;
        return {l, r};
    endfunction
    function automatic logic [7:0] gdec(input logic [7:0] c, input logic [7:0] k);
        logic [3:0] l, r, t;
        l = c[7:4]; r = c[3:0];
        t = r ^ rf(l, k[7:4]); r = l; l = t;
        t = r ^ rf(l, k[3:0]); r = l; l = t;
        return {l, r};
    endfunction
    function automatic logic [7:0] kseg(input int s);
        logic [7:0] v;
        v = 8'((s % 16) * 17);
        return v;
    endfunction

    // behavioural cipher core
    typedef enum logic [1:0] {C_IDLE, C_KEY, C_SEG, C_STR} core_st_e;
    core_st_e   cst;
    logic [7:0] ckey [16];
    logic [3:0] ckcnt, cseg;
    logic       cfirst;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            cst <= C_IDLE; ckcnt <= 0; cseg <= 0; cfirst <= 0; cph_uo <= 0;
            for (int i = 0; i < 16; i++) ckey[i] <= 8'h00;
        end else begin
            case (cst)
                C_IDLE: begin
                    cph_uo <= 8'h00;
                    if (cph_ui == 8'h01) begin cst <= C_KEY; ckcnt <= 0; end
                    else if (cph_ui == 8'h0F) cst <= C_SEG;
                    else if (cph_ui == 8'h02) begin cst <= C_STR; cfirst <= 1'b1; end
                end
                C_KEY: begin
                    ckey[ckcnt] <= cph_ui;
                    ckcnt <= ckcnt + 4'd1;
                    if (ckcnt == 4'd15) cst <= C_IDLE;
                end
                C_SEG: begin cseg <= cph_ui[3:0]; cst <= C_IDLE; end
                C_STR: begin
                    cph_uo <= cfirst ? 8'h00 :
                              (cph_uio[0] ? gdec(cph_ui, ckey[cseg]) : genc(cph_ui, ckey[cseg]));
                    cfirst <= 1'b0;
                    cseg   <= cseg + 4'd1;
                    if (cph_uio[1]) cst <= C_IDLE;
                end
                default: cst <= C_IDLE;
            endcase
        end
    end

    int total = 0;
    int bad   = 0;
    logic [7:0] sb[$];
    logic [7:0] dout_log[$];
    logic [7:0] fed[$];
    logic [7:0] mon_exp;
    int cyc = 0, first_cyc = 0, last_cyc = 0;
    logic [7:0] seq_ui [64];
    logic [7:0] seq_uio[64];
    int seg_exp = 0, last_start = 0;

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst && bus.dout_valid) begin
            if (dout_log.size() == 0) first_cyc = cyc;
            last_cyc = cyc;
            dout_log.push_back(bus.dout_byte);
            total++;
            assert (sb.size() > 0) else begin
                bad++; $error("FAIL sb_unexpected observed=%02h expected=none", bus.dout_byte);
            end
            if (sb.size() > 0) begin
                mon_exp = sb.pop_front();
                total++;
                assert (bus.dout_byte === mon_exp) else begin
                    bad++; $error("FAIL dout observed=%02h expected=%02h", bus.dout_byte, mon_exp);
                end
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++; $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_cmd(input logic [1:0] op, input logic [7:0] arg, input logic dec,
                            input logic [127:0] key);
        int n = 0;
        while (!bus.cmd_ready && n < 200) begin @(negedge clk); n++; end
        chk("idle_wait_bound", 32'(n < 200), 1);
        bus.cmd_op = op; bus.cmd_arg = arg; bus.cmd_dec = dec; bus.cmd_key = key;
        bus.cmd_valid = 1'b1;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
    endtask

    task automatic capture(output int n);
        bit rdy_seen = 0;
        n = 0;
        while (busy && n < 64) begin
            seq_ui[n] = cph_ui; seq_uio[n] = cph_uio;
            if (bus.cmd_ready) rdy_seen = 1;
            n++;
            @(negedge clk);
        end
        chk("busy_bound", 32'(busy), 0);
        chk("cmd_ready_low_while_busy", 32'(rdy_seen), 0);
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.din_valid = 1'b1; bus.din_byte = b;
        @(negedge clk);
        bus.din_valid = 1'b0;
    endtask

    task automatic set_start(input logic [7:0] s);
        int n;
        send_cmd(OP_SET_START, s, 1'b0, '0);
        capture(n);
        chk("set_busy_cycles", n, 2);
        chk("set_cmd_byte", seq_ui[0], 8'h0F);
        chk("set_arg_byte", seq_ui[1], s);
        last_start = s; seg_exp = s;
    endtask

    function automatic int next_start();
        return RESYNC ? last_start : seg_exp;
    endfunction

    // checks the tail of the captured drive sequence and the result timing
    task automatic check_stream(input int n, input int L, input logic dec);
        if (n < L + 3 + PRE) chk("stream_len_short", n, L + 3 + PRE);
        else begin
`ifdef FEISTEL_SEQ_RESYNC_EN
            chk("resync_cmd", seq_ui[0], 8'h0F);
            chk("resync_arg", seq_ui[1], 8'(last_start));
`endif
            chk("str_cmd", seq_ui[n-L-3], 8'h02);
            chk("str_pad", seq_ui[n-L-2], 8'h00);
            for (int i = 0; i < L; i++) begin
                chk($sformatf("str_data%0d", i), seq_ui[n-L-1+i], fed[i]);
                chk($sformatf("str_uio%0d", i), seq_uio[n-L-1+i],
                    {6'b0, (i == L-1), dec});
            end
            chk("drain_ui", seq_ui[n-1], 8'h00);
        end
        repeat (3) @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        chk("dout_count", dout_log.size(), L);
        chk("dout_consecutive", last_cyc - first_cyc, L - 1);
    endtask

    task automatic stream_run(input int L, input logic dec, output int n);
        send_cmd(OP_STREAM, 8'(L - 1), dec, '0);
        capture(n);
    endtask

    logic [7:0] orig[8];
    logic [7:0] enc_out[8];
    logic [7:0] outa[4];
    int n, start;
    bit same;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.cmd_valid = 0; bus.cmd_op = 0; bus.cmd_arg = 0; bus.cmd_dec = 0; bus.cmd_key = '0;
        bus.din_valid = 0; bus.din_byte = 0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_din_ready", bus.din_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_dout_valid", bus.dout_valid, 0);
        chk("rst_cph_ui", cph_ui, 0);
        rst = 1'b0;
        @(negedge clk);

        // reserved opcode is a no-op
        send_cmd(OP_RSVD, 8'hAA, 1'b1, '0);
        chk("rsvd_busy", busy, 0);
        chk("rsvd_cmd_ready", bus.cmd_ready, 1);

        // key load
        send_cmd(OP_LOAD_KEY, 8'h00, 1'b0, 128'h00112233445566778899AABBCCDDEEFF);
        capture(n);
        chk("key_busy_cycles", n, 17);
        chk("key_cmd_byte", seq_ui[0], 8'h01);
        for (int k = 0; k < 16; k++) chk($sformatf("key_byte%0d", k), seq_ui[k+1], kseg(k));

        // SET_START 5, one-byte encrypt: data uses segment 6
        set_start(8'h05);
        fed.delete(); fed.push_back(8'h3C);
        push_byte(8'h3C);
        start = next_start();
        sb.push_back(genc(8'h3C, kseg(start + 1)));
        dout_log.delete();
        stream_run(1, 1'b0, n);
        chk("l1_busy_cycles", n, 4 + PRE);
        check_stream(n, 1, 1'b0);
        seg_exp = (start + 2) % 16;

        // L=16 with only 4 buffered: waits for the remaining 12
        fed.delete();
        for (int i = 0; i < 16; i++) fed.push_back(8'($urandom_range(0, 255)));
        for (int i = 0; i < 4; i++) push_byte(fed[i]);
        start = next_start();
        for (int i = 0; i < 16; i++) sb.push_back(genc(fed[i], kseg(start + 1 + i)));
        dout_log.delete();
        send_cmd(OP_STREAM, 8'h0F, 1'b0, '0);
        fork
            capture(n);
            begin
                repeat (6) @(negedge clk);
                chk("wait_busy", busy, 1);
                chk("wait_ui_zero", cph_ui, 0);
                chk("wait_no_dout", dout_log.size(), 0);
                for (int i = 4; i < 16; i++) push_byte(fed[i]);
                chk("fifo_full_din_ready", bus.din_ready, 0);
            end
        join
        chk("wait_extended_busy", 32'(n > 19 + PRE), 1);
        check_stream(n, 16, 1'b0);
        seg_exp = (start + 17) % 16;

        // encrypt 8 then decrypt from the same start segment
        set_start(8'h0A);
        fed.delete();
        for (int i = 0; i < 8; i++) begin
            orig[i] = 8'($urandom_range(0, 255));
            fed.push_back(orig[i]);
            push_byte(orig[i]);
        end
        start = next_start();
        for (int i = 0; i < 8; i++) sb.push_back(genc(orig[i], kseg(start + 1 + i)));
        dout_log.delete();
        stream_run(8, 1'b0, n);
        chk("enc8_busy_cycles", n, 11 + PRE);
        check_stream(n, 8, 1'b0);
        for (int i = 0; i < 8; i++) enc_out[i] = (i < dout_log.size()) ? dout_log[i] : 8'h00;
        set_start(8'h0A);
        fed.delete();
        for (int i = 0; i < 8; i++) begin
            fed.push_back(enc_out[i]);
            push_byte(enc_out[i]);
            sb.push_back(orig[i]);
        end
        dout_log.delete();
        stream_run(8, 1'b1, n);
        check_stream(n, 8, 1'b1);
        seg_exp = (next_start() + 9) % 16;

        // two back-to-back identical L=4 bursts
        fed.delete();
        for (int i = 0; i < 4; i++) fed.push_back(8'(8'h10 * (i + 1)));
        for (int r = 0; r < 2; r++) for (int i = 0; i < 4; i++) push_byte(fed[i]);
        start = next_start();
        for (int i = 0; i < 4; i++) sb.push_back(genc(fed[i], kseg(start + 1 + i)));
        seg_exp = (start + 5) % 16;
        dout_log.delete();
        stream_run(4, 1'b0, n);
        check_stream(n, 4, 1'b0);
        for (int i = 0; i < 4; i++) outa[i] = (i < dout_log.size()) ? dout_log[i] : 8'h00;
        start = next_start();
        for (int i = 0; i < 4; i++) sb.push_back(genc(fed[i], kseg(start + 1 + i)));
        seg_exp = (start + 5) % 16;
        dout_log.delete();
        stream_run(4, 1'b0, n);
        check_stream(n, 4, 1'b0);
        same = 1;
        for (int i = 0; i < 4; i++)
            if (i >= dout_log.size() || dout_log[i] !== outa[i]) same = 0;
        chk("bursts_identical", 32'(same), 32'(RESYNC));

        // reset in the middle of STR_DATA (decrypt, so mode bit is set)
        for (int i = 0; i < 8; i++) push_byte(8'(i + 1));
        dout_log.delete();
        send_cmd(OP_STREAM, 8'h07, 1'b1, '0);
        repeat (3 + PRE) @(negedge clk);
        chk("mid_mode_bit", cph_uio[0], 1);
        chk("mid_busy", busy, 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_cmd_ready", bus.cmd_ready, 1);
        chk("arst_din_ready", bus.din_ready, 1);
        chk("arst_busy", busy, 0);
        chk("arst_dout_valid", bus.dout_valid, 0);
        chk("arst_dout_byte", bus.dout_byte, 0);
        chk("arst_cph_ui", cph_ui, 0);
        chk("arst_cph_uio", cph_uio, 0);
        sb.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (20) @(negedge clk);
        chk("post_rst_no_dout", dout_log.size(), 0);
        chk("post_rst_idle", busy, 0);
        // FIFO was emptied: a one-byte stream has to wait
        send_cmd(OP_STREAM, 8'h00, 1'b0, '0);
        repeat (4 + PRE) @(negedge clk);
        chk("post_rst_fifo_empty_wait", busy, 1);
        chk("post_rst_wait_ui", cph_ui, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/feistel_seq_ctrl.md
# feistel_seq_ctrl

Sequencer and front-end for the 8-bit Feistel cipher core. It turns word-level host commands (load key, set start segment, stream N bytes) into the core's byte-serial command protocol on its `ui_in`/`uio_in` pins. It buffers plaintext/ciphertext in a 16-entry FIFO so every stream burst is contiguous, and it strips the core's pipeline artefacts from the returned bytes. It sits between the host bus and the cipher core.

## Interface
- `DIN_DEPTH`, 16: input FIFO depth, in bytes (power of two, ≥16).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  reset, asynchronous, active-high; must reset the core at the same time.
- `cmd_valid`/`cmd_ready`  in/out  1  command handshake; transfer when both are high.
- `cmd_op`  in  2  00 LOAD_KEY, 01 SET_START, 10 STREAM, 11 reserved.
- `cmd_arg`  in  8  SET_START: segment byte; STREAM: `[3:0]` = length−1 (L = 1..16).
- `cmd_dec`  in  1  STREAM: 1 = decrypt.
- `cmd_key`  in  128  LOAD_KEY: key; `[127:120]` is sent first.
- `din_valid`/`din_ready`  in/out  1  input byte handshake; `din_ready` = FIFO not full.
- `din_byte`  in  8  input byte.
- `dout_valid`  out  1  one-cycle strobe per result byte; there is no backpressure.
- `dout_byte`  out  8  result byte.
- `busy`  out  1  high when the FSM is not IDLE.
- `cph_ui`  out  8  drives the core's `ui_in`.
- `cph_uio`  out  8  drives the core's `uio_in`: bit0 = mode, bit1 = end_stream, other bits 0.
- `cph_uo`  in  8  the core's `uo_out`.

## Operation
- Reset values:
  - `cmd_ready` = 1.
  - `din_ready` = 1.
  - `busy`, `dout_valid` = 0.
  - `dout_byte`, `cph_ui`, `cph_uio` = 0.
  - FIFO empty; FSM in IDLE; mode register = 0.
- `cph_ui` = 0x00 in every state that does not drive it explicitly, because 0x01, 0x0F or 0x02 on an idle core starts a command.
- FSM states: IDLE, KEY_CMD, KEY_DATA, ST_CMD, ST_ARG, WAIT_DATA, STR_CMD, STR_PAD, STR_DATA, DRAIN.
- IDLE: `cmd_ready` = 1. An accepted command latches `op`, `arg`, `dec` and `key`.
  - LOAD_KEY → KEY_CMD.
  - SET_START → ST_CMD.
  - STREAM → WAIT_DATA.
  - Reserved op: accepted, no-op, stays in IDLE.
- KEY_CMD: drive 0x01, then go to KEY_DATA.
- KEY_DATA: 16 cycles; cycle k drives `key[127-8k -: 8]`; go to IDLE after k = 15.
- ST_CMD: drive 0x0F. ST_ARG: drive `arg`, then go to IDLE.
- WAIT_DATA: wait until FIFO count ≥ L, then go to STR_CMD. This state is skipped (zero cycles) if the condition already holds on entry.
- STR_CMD: drive 0x02. STR_PAD: drive 0x00 as a sacrificial byte; the core masks its first streaming output, and this byte consumes one key segment.
- STR_DATA: L cycles; pop one FIFO byte per cycle onto `cph_ui`. `cph_uio[1]` = 1 on the last cycle.
- DRAIN: one cycle, then go to IDLE.
- `cph_uio[0]` = latched `dec` from STR_CMD through DRAIN. In all other states it holds the last latched value.
- Capture: when the previous cycle was STR_DATA, register `cph_uo` into `dout_byte` and pulse `dout_valid` on the next cycle.
- FIFO keeps accepting `din` in every state, including during a stream. A push and a pop in the same cycle leave the count unchanged.
- Core segment index advances mod 16 on every streaming cycle, including the pad. A stream of length L advances it by L+1.
- A reset mid-operation aborts immediately. Both controller and core return to idle; FIFO content is discarded.

## Timing
- Command accept to the first `cph_ui` command byte: 1 cycle.
- LOAD_KEY: 17 cycles busy. SET_START: 2 cycles. STREAM: 2+L+1 cycles plus any WAIT_DATA cycles.
- Byte popped in cycle t → `cph_uo` valid in t+1 → `dout_valid` in t+2.
- Bytes out = L exactly, in FIFO order, on consecutive cycles.
- `cmd_ready` is low from the cycle after accept until the FSM is back in IDLE. The next command is accepted on the first IDLE cycle.

## Configuration
- `FEISTEL_SEQ_RESYNC_EN`
  - Defined: a STREAM command automatically inserts ST_CMD/ST_ARG (2 cycles) before STR_CMD, re-sending the last SET_START byte (0x00 after reset). Every burst then starts at the same key segment, which makes encrypt and decrypt of the same burst symmetric.
  - Undefined: the segment index carries over between bursts.

## Structure
- Package `feistel_seq_pkg`:
  - opcode constants;
  - core command bytes 0x01/0x0F/0x02;
  - FSM state enum;
  - `KEY_BYTES` = 16.
- Sub-module `feistel_seq_fifo`: synchronous byte FIFO with count output. The FSM and the capture logic stay in the top level.

## Test plan
- LOAD_KEY with `cmd_key` = 0x00112233…FF → `cph_ui` = 0x01, then 0x00, 0x11, …, 0xFF over 16 cycles; `busy` for 17 cycles.
- SET_START arg 0x05, then push 0x3C, STREAM L = 1 enc → `cph_ui` = 0x0F, 0x05, …, 0x02, 0x00, 0x3C with end_stream; one `dout_valid` equal to the golden-model output for segment 6.
- STREAM L = 16 with only 4 bytes buffered → stays in WAIT_DATA until the 16th push. Then 16 consecutive `dout_valid` strobes matching the model.
- Encrypt 8 bytes, then SET_START to the same value and decrypt the 8 results (`cmd_dec` = 1) → the original 8 bytes are recovered.
- Assert `rst` in the middle of STR_DATA → all outputs return to reset values asynchronously; `dout_valid` is never asserted afterwards.
- With `FEISTEL_SEQ_RESYNC_EN` defined, two back-to-back STREAMs of identical data (L = 4) → identical outputs. With it undefined → outputs differ.
